// File: rtl/window_addr_pkg.sv
// Shared types and constant helpers for the sliding-window address generator.
package window_addr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int tap_count(input int w);
    return (2 * w + 1) * (2 * w + 1);
  endfunction

  function automatic int min_dim(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/window_addr_gen_raster_counter.sv
// Nested (row, column) counter with inclusive bounds; the row base accumulates
// i_stride per row so callers get row*stride without a multiplier.
module raster_counter #(
  parameter int DIM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_adv,
  input  logic [DIM_WIDTH-1:0]  i_row_lo,
  input  logic [DIM_WIDTH-1:0]  i_row_hi,
  input  logic [DIM_WIDTH-1:0]  i_col_lo,
  input  logic [DIM_WIDTH-1:0]  i_col_hi,
  input  logic [ADDR_WIDTH-1:0] i_base_init,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  output logic [DIM_WIDTH-1:0]  o_col,
  output logic [ADDR_WIDTH-1:0] o_base,
  output logic                  o_wrap
);

  logic [DIM_WIDTH-1:0]  r_row;
  logic [DIM_WIDTH-1:0]  r_col;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  w_col_end;
  logic                  w_row_end;

  assign w_col_end = (r_col == i_col_hi);
  assign w_row_end = (r_row == i_row_hi);
  assign o_wrap    = w_col_end && w_row_end;
  assign o_col     = r_col;
  assign o_base    = r_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_base <= '0;
    end else if (i_load) begin
      r_row  <= i_row_lo;
      r_col  <= i_col_lo;
      r_base <= i_base_init;
    end else if (i_adv) begin
      if (w_col_end) begin
        r_col <= i_col_lo;
        if (w_row_end) begin
          r_row  <= i_row_lo;
          r_base <= i_base_init;
        end else begin
          r_row  <= r_row + 1'b1;
          r_base <= r_base + i_stride;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_addr_gen.sv
// Sliding-window address generator: walks interior centres of an MxN frame and
// emits tap addresses. Macro WINDOW_ADDR_TAPS_EN enables full tap enumeration.
module window_addr_gen
  import window_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 16,
  parameter int WINDOW_N   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  M,
  input  logic [DIM_WIDTH-1:0]  N,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addrP,
  output logic [ADDR_WIDTH-1:0] addrW,
  output logic [DIM_WIDTH-1:0]  tap_idx,
  output logic                  last_tap,
  output logic                  last_pixel,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [DIM_WIDTH-1:0] W_D   = DIM_WIDTH'(WINDOW_N);
  localparam logic [DIM_WIDTH-1:0] MIN_D = DIM_WIDTH'(min_dim(WINDOW_N));

  // W*N by repeated addition; WINDOW_N is a small elaboration constant.
  function automatic logic [ADDR_WIDTH-1:0] times_w(input logic [ADDR_WIDTH-1:0] n);
    logic [ADDR_WIDTH-1:0] acc;
    acc = '0;
    for (int k = 0; k < WINDOW_N; k++) acc = acc + n;
    return acc;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [DIM_WIDTH-1:0]  r_m, r_n;
  logic                  r_err;
  logic                  w_bad, w_start, w_load, w_accept, w_final;
  logic                  w_c_adv, w_c_wrap, w_t_wrap;
  logic [DIM_WIDTH-1:0]  w_row_hi, w_col_hi, w_c_col;
  logic [ADDR_WIDTH-1:0] w_wn, w_stride, w_c_base, w_addr_p;

  assign w_bad    = (M < MIN_D) || (N < MIN_D);
  assign w_start  = (r_state == IDLE) && start;
  assign w_load   = w_start && !w_bad;
  assign w_accept = addr_valid && addr_ready;
  assign w_final  = w_accept && w_t_wrap && w_c_wrap;
  assign w_c_adv  = w_accept && w_t_wrap;
  assign w_wn     = times_w(ADDR_WIDTH'(N));
  assign w_stride = ADDR_WIDTH'(r_n);
  assign w_row_hi = r_m - W_D - DIM_WIDTH'(1);
  assign w_col_hi = r_n - W_D - DIM_WIDTH'(1);

  raster_counter #(.DIM_WIDTH(DIM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_centre (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_adv      (w_c_adv),
    .i_row_lo   (W_D),
    .i_row_hi   (w_row_hi),
    .i_col_lo   (W_D),
    .i_col_hi   (w_col_hi),
    .i_base_init(w_wn),
    .i_stride   (w_stride),
    .o_col      (w_c_col),
    .o_base     (w_c_base),
    .o_wrap     (w_c_wrap)
  );

  assign w_addr_p = w_c_base + ADDR_WIDTH'(w_c_col);

`ifdef WINDOW_ADDR_TAPS_EN
  localparam logic [DIM_WIDTH-1:0] T_HI = DIM_WIDTH'(2 * WINDOW_N);

  logic [DIM_WIDTH-1:0]  w_t_col, r_tap_idx;
  logic [ADDR_WIDTH-1:0] w_t_base, r_off;

  raster_counter #(.DIM_WIDTH(DIM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_tap (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_adv      (w_accept),
    .i_row_lo   ('0),
    .i_row_hi   (T_HI),
    .i_col_lo   ('0),
    .i_col_hi   (T_HI),
    .i_base_init('0),
    .i_stride   (w_stride),
    .o_col      (w_t_col),
    .o_base     (w_t_base),
    .o_wrap     (w_t_wrap)
  );

  // r_off is W*N+W: distance from centre back to the window's top-left tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_off     <= '0;
      r_tap_idx <= '0;
    end else if (w_load) begin
      r_off     <= w_wn + ADDR_WIDTH'(WINDOW_N);
      r_tap_idx <= '0;
    end else if (w_accept) begin
      r_tap_idx <= w_t_wrap ? '0 : r_tap_idx + 1'b1;
    end
  end

  assign addrW    = addr_valid ? (w_addr_p - r_off + w_t_base + ADDR_WIDTH'(w_t_col)) : '0;
  assign tap_idx  = addr_valid ? r_tap_idx : '0;
  assign last_tap = addr_valid && w_t_wrap;
`else
  assign w_t_wrap = 1'b1;
  assign addrW    = addrP;
  assign tap_idx  = '0;
  assign last_tap = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_bad ? DONE : RUN;
      RUN:     if (w_final) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_n     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_m   <= M;
        r_n   <= N;
        r_err <= w_bad;
      end else if (r_state == DONE) begin
        r_err <= 1'b0;
      end
    end
  end

  assign addr_valid = (r_state == RUN);
  assign busy       = addr_valid;
  assign done       = (r_state == DONE);
  assign err        = done && r_err;
  assign addrP      = addr_valid ? w_addr_p : '0;
  assign last_pixel = addr_valid && w_t_wrap && w_c_wrap;

endmodule

// File: tb/tb_window_addr_gen.sv
// Scoreboard bench for window_addr_gen: W=1 and W=2 instances, directed scans.
module tb_window_addr_gen;

`ifdef WINDOW_ADDR_TAPS_EN
  localparam bit TAPS = 1'b1;
`else
  localparam bit TAPS = 1'b0;
`endif
  localparam int NB1    = TAPS ? 81 : 9;
  localparam int NB2    = TAPS ? 25 : 1;
  localparam int RST_AT = TAPS ? 20 : 5;

  typedef struct {
    int p; int w; int t; int lt; int lp;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1;
  logic st1 = 1'b0, st2 = 1'b0, rdy1 = 1'b1, rdy2 = 1'b1;
  logic [15:0] m1 = '0, n1 = '0, m2 = '0, n2 = '0;
  logic v1, lt1, lp1, b1, d1, e1, v2, lt2, lp2, b2, d2, e2;
  logic [15:0] p1, w1, t1, p2, w2, t2;

  beat_t q1[$], q2[$];
  int total = 0, bad = 0;
  int acc1 = 0, acc2 = 0, pend1 = 0, pend2 = 0;
  int logw[0:511];

  always #5 clk = ~clk;

  window_addr_gen #(.ADDR_WIDTH(16), .DIM_WIDTH(16), .WINDOW_N(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .M(m1), .N(n1),
    .addr_valid(v1), .addr_ready(rdy1), .addrP(p1), .addrW(w1), .tap_idx(t1),
    .last_tap(lt1), .last_pixel(lp1), .busy(b1), .done(d1), .err(e1));

  window_addr_gen #(.ADDR_WIDTH(16), .DIM_WIDTH(16), .WINDOW_N(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(st2), .M(m2), .N(n2),
    .addr_valid(v2), .addr_ready(rdy2), .addrP(p2), .addrW(w2), .tap_idx(t2),
    .last_tap(lt2), .last_pixel(lp2), .busy(b2), .done(d2), .err(e2));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference scan: raster centres, raster taps, plain multiplication.
  task automatic push_scan(input int which, input int m, input int n, input int w);
    beat_t e;
    int r, k;
    r = TAPS ? w : 0;
    for (int i = w; i <= m - w - 1; i++)
      for (int j = w; j <= n - w - 1; j++) begin
        k = 0;
        for (int di = -r; di <= r; di++)
          for (int dj = -r; dj <= r; dj++) begin
            e.p  = (i * n + j) & 16'hFFFF;
            e.w  = ((i + di) * n + j + dj) & 16'hFFFF;
            e.t  = k;
            e.lt = (di == r && dj == r) ? 1 : 0;
            e.lp = (e.lt == 1 && i == m - w - 1 && j == n - w - 1) ? 1 : 0;
            if (which == 1) q1.push_back(e); else q2.push_back(e);
            k++;
          end
      end
  endtask

  task automatic check_beat(input string tag, input beat_t e, input int p, input int w,
                            input int t, input int lt, input int lp);
    chk({tag, "_addrP"}, p, e.p);
    chk({tag, "_addrW"}, w, e.w);
    chk({tag, "_tap_idx"}, t, e.t);
    chk({tag, "_last_tap"}, lt, e.lt);
    chk({tag, "_last_pixel"}, lp, e.lp);
  endtask

  // Monitor for the W=1 instance: scoreboard pop, stall-hold check, done pulse.
  initial begin
    beat_t e, hold;
    bit stalled;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
        pend1 = 0;
      end else begin
        if (pend1 == 1) begin
          chk("d1_done_pulse", int'(d1), 1);
          chk("d1_busy_fall", int'(b1), 0);
          chk("d1_err_clear", int'(e1), 0);
          pend1 = 2;
        end else if (pend1 == 2) begin
          chk("d1_done_once", int'(d1), 0);
          pend1 = 0;
        end
        if (stalled && v1) begin
          chk("stall_hold_addrP", int'(p1), hold.p);
          chk("stall_hold_addrW", int'(w1), hold.w);
          chk("stall_hold_tap", int'(t1), hold.t);
        end
        if (v1 && rdy1) begin
          if (q1.size() == 0) chk("d1_unexpected_beat", 1, 0);
          else begin
            e = q1.pop_front();
            check_beat("d1", e, int'(p1), int'(w1), int'(t1), int'(lt1), int'(lp1));
          end
          if (acc1 < 512) logw[acc1] = int'(w1);
          acc1++;
          if (lp1) pend1 = 1;
        end
        stalled = v1 && !rdy1;
        hold.p = int'(p1); hold.w = int'(w1); hold.t = int'(t1);
      end
    end
  end

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) pend2 = 0;
      else begin
        if (pend2 == 1) begin
          chk("d2_done_pulse", int'(d2), 1);
          chk("d2_busy_fall", int'(b2), 0);
          pend2 = 0;
        end
        if (v2 && rdy2) begin
          if (q2.size() == 0) chk("d2_unexpected_beat", 1, 0);
          else begin
            e = q2.pop_front();
            check_beat("d2", e, int'(p2), int'(w2), int'(t2), int'(lt2), int'(lp2));
          end
          acc2++;
          if (lp2) pend2 = 1;
        end
      end
    end
  end

  task automatic start1(input int m, input int n);
    @(posedge clk); #1;
    m1 = 16'(m); n1 = 16'(n); st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    int c;
    c = 0;
    while (!d1 && c < budget) begin @(negedge clk); c++; end
    if (c >= budget) chk("d1_timeout", 0, 1);
  endtask

  initial begin
    int base, c, exp_lt_idle, exp_first[9], exp_last;
`ifdef WINDOW_ADDR_TAPS_EN
    exp_first = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    exp_last = 24;
    exp_lt_idle = 0;
`else
    exp_first = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    exp_last = 18;
    exp_lt_idle = 1;
`endif
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(v1), 0);   chk("rst_addrP", int'(p1), 0);
    chk("rst_addrW", int'(w1), 0);   chk("rst_tap_idx", int'(t1), 0);
    chk("rst_last_tap", int'(lt1), exp_lt_idle);
    chk("rst_last_pixel", int'(lp1), 0);
    chk("rst_busy", int'(b1), 0);    chk("rst_done", int'(d1), 0);
    chk("rst_err", int'(e1), 0);
    @(posedge clk); #1 rst = 1'b0;

    // A: 5x5, W=1, ready high
    base = acc1;
    push_scan(1, 5, 5, 1);
    start1(5, 5);
    @(negedge clk);
    chk("A_latency_valid", int'(v1), 1);
    chk("A_latency_busy", int'(b1), 1);
    wait_done1(400);
    repeat (3) @(posedge clk);
    chk("A_beat_count", acc1 - base, NB1);
    for (int k = 0; k < 9; k++) chk("A_first_addrW", logw[base + k], exp_first[k]);
    chk("A_last_addrW", logw[base + NB1 - 1], exp_last);

    // B: 5x5, W=2 on the second instance
    push_scan(2, 5, 5, 2);
    @(posedge clk); #1;
    m2 = 16'd5; n2 = 16'd5; st2 = 1'b1;
    @(posedge clk); #1 st2 = 1'b0;
    c = 0;
    while (!d2 && c < 200) begin @(negedge clk); c++; end
    if (c >= 200) chk("B_timeout", 0, 1);
    repeat (2) @(posedge clk);
    chk("B_beat_count", acc2, NB2);

    // C: illegal dimensions
    base = acc1;
    start1(2, 5);
    @(negedge clk);
    chk("C_done", int'(d1), 1);  chk("C_err", int'(e1), 1);
    chk("C_valid", int'(v1), 0); chk("C_busy", int'(b1), 0);
    @(negedge clk);
    chk("C_done_once", int'(d1), 0); chk("C_err_once", int'(e1), 0);
    chk("C_no_beats", acc1 - base, 0);

    // D: ready toggling 1-0-0-1
    base = acc1;
    push_scan(1, 5, 5, 1);
    start1(5, 5);
    c = 0;
    while (c < 800) begin
      rdy1 = (c % 4 == 0) || (c % 4 == 3);
      c++;
      @(negedge clk);
      if (d1) break;
      @(posedge clk); #1;
    end
    if (c >= 800) chk("D_timeout", 0, 1);
    rdy1 = 1'b1;
    repeat (3) @(posedge clk);
    chk("D_beat_count", acc1 - base, NB1);

    // E: reset during a scan, then restart
    base = acc1;
    push_scan(1, 5, 5, 1);
    start1(5, 5);
    c = 0;
    while (acc1 - base < RST_AT && c < 400) begin @(negedge clk); #1; c++; end
    if (c >= 400) chk("E_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("E_rst_valid", int'(v1), 0); chk("E_rst_addrP", int'(p1), 0);
    chk("E_rst_addrW", int'(w1), 0); chk("E_rst_tap", int'(t1), 0);
    chk("E_rst_last_tap", int'(lt1), exp_lt_idle);
    chk("E_rst_last_pixel", int'(lp1), 0);
    chk("E_rst_busy", int'(b1), 0);  chk("E_rst_done", int'(d1), 0);
    q1.delete();
    @(posedge clk); #1 rst = 1'b0;
    base = acc1;
    push_scan(1, 5, 5, 1);
    start1(5, 5);
    @(negedge clk);
    chk("E_restart_valid", int'(v1), 1);
    chk("E_restart_addrW", int'(w1), exp_first[0]);
    wait_done1(400);
    repeat (3) @(posedge clk);
    chk("E_beat_count", acc1 - base, NB1);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
